recip_round_pack: RTL and testbench

Output stage of the floating-point reciprocal unit. It sits directly downstream of the SRT significand calculator: it takes the normalized quotient significand and its guard/round/sticky bits, plus the operand's sign, exponent and class. It rounds under a selectable mode, computes the result exponent, handles specials, overflow and underflow, and packs an IEEE-754 word with exception flags. It is a two-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/recip_round_pack.sv | 162 ++++++++++++++++
 tb/tb_recip_round_pack.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recip_round_pack.sv
// Reciprocal output stage: rounds the SRT quotient, derives the result
// exponent, resolves specials/overflow/underflow and packs the IEEE word.
module recip_round_pack #(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [sig_width:0]             q_sig,
  input  logic                           g_bit,
  input  logic                           r_bit,
  input  logic                           s_bit,
  input  logic                           in_sign,
  input  logic [exp_width-1:0]           in_exp,
  input  logic                           d_frac_zero,
  input  logic [1:0]                     in_class,
  input  logic [1:0]                     rnd_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [exp_width+sig_width:0]   out_result,
  output logic [3:0]                     out_flags
);

  localparam int SW   = sig_width;
  localparam int EW   = exp_width;
  localparam int W    = 1 + EW + SW;
  localparam int BIAS = (1 << (EW - 1)) - 1;

  typedef logic signed [EW+1:0] sexp_t;

  localparam sexp_t TWO_BIAS = sexp_t'(2 * BIAS);
  localparam sexp_t EMAX     = sexp_t'((1 << EW) - 1);

  localparam logic [1:0] C_ZERO = 2'd1;
  localparam logic [1:0] C_INF  = 2'd2;
  localparam logic [1:0] C_NAN  = 2'd3;

  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RTZ = 2'd1;
  localparam logic [1:0] RUP = 2'd2;
  localparam logic [1:0] RDN = 2'd3;

  localparam logic [W-2:0] INF_MAG = {{EW{1'b1}}, {SW{1'b0}}};
  localparam logic [W-2:0] MAX_MAG = {{(EW-1){1'b1}}, 1'b0, {SW{1'b1}}};
  localparam logic [W-1:0] QNAN    = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};

  logic          s1_valid_q, s1_valid_d;
  logic          s1_sign_q;
  logic [1:0]    s1_class_q;
  logic [1:0]    s1_mode_q;
  logic [SW:0]   s1_sig_q;
  sexp_t         s1_exp_q;
  logic          s1_inexact_q;
  logic          s1_inc_q;

  logic          s2_valid_q, s2_valid_d;
  logic [W-1:0]  res_q, res_d;
  logic [3:0]    flags_q, flags_d;

  logic          s1_load, s2_adv, s2_load;
  sexp_t         exp_d;
  logic          any_d, inc_d;

  assign s2_adv     = ~s2_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s2_adv;
  assign s1_load    = in_valid & in_ready;
  assign s2_load    = s1_valid_q & s2_adv;
  assign s1_valid_d = in_ready ? in_valid : s1_valid_q;
  assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

  assign exp_d = TWO_BIAS - sexp_t'(in_exp)
               - sexp_t'(!d_frac_zero);

  always_comb begin
    any_d = g_bit | r_bit | s_bit;
    inc_d = 1'b0;
    unique case (rnd_mode)
      RNE:     inc_d = g_bit & (r_bit | s_bit | q_sig[0]);
      RTZ:     inc_d = 1'b0;
      RUP:     inc_d = ~in_sign & any_d;
      default: inc_d = in_sign & any_d;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_class_q   <= '0;
      s1_mode_q    <= '0;
      s1_sig_q     <= '0;
      s1_exp_q     <= '0;
      s1_inexact_q <= 1'b0;
      s1_inc_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_sign_q    <= in_sign;
        s1_class_q   <= in_class;
        s1_mode_q    <= rnd_mode;
        s1_sig_q     <= q_sig;
        s1_exp_q     <= exp_d;
        s1_inexact_q <= any_d;
        s1_inc_q     <= inc_d;
      end
    end
  end

  logic [SW+1:0] sum;
  sexp_t         e2;
  logic          is_unf, is_ovf, ovf_inf;

  always_comb begin
    sum = {1'b0, s1_sig_q} + (SW+2)'(s1_inc_q);
    // Top two sum bits are 01 normally, 10 on round carry: exponent step.
    e2 = s1_exp_q + sexp_t'(sum[SW+1:SW]) - sexp_t'(1);
    is_unf  = e2[EW+1] | (e2 == '0);
    is_ovf  = ~e2[EW+1] & (e2 >= EMAX);
    ovf_inf = (s1_mode_q == RNE)
            | ((s1_mode_q == RUP) & ~s1_sign_q)
            | ((s1_mode_q == RDN) & s1_sign_q);
    res_d   = {s1_sign_q, e2[EW-1:0], sum[SW-1:0]};
    flags_d = {3'b000, s1_inexact_q};
    if (s1_class_q == C_NAN) begin
      res_d   = QNAN;
      flags_d = 4'b0000;
    end else if (s1_class_q == C_ZERO) begin
      res_d   = {s1_sign_q, INF_MAG};
      flags_d = 4'b1000;
    end else if (s1_class_q == C_INF) begin
      res_d   = {s1_sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (is_unf) begin
      res_d   = {s1_sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else if (is_ovf) begin
      res_d   = {s1_sign_q, ovf_inf ? INF_MAG : MAX_MAG};
      flags_d = 4'b0101;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = res_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_recip_round_pack.sv
// Scoreboard bench for recip_round_pack (single-precision configuration).
module tb_recip_round_pack;
  localparam int SW = 23;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW:0]   q_sig = '0;
  logic          g_bit = 1'b0, r_bit = 1'b0, s_bit = 1'b0;
  logic          in_sign = 1'b0;
  logic [EW-1:0] in_exp = '0;
  logic          d_frac_zero = 1'b0;
  logic [1:0]    in_class = '0;
  logic [1:0]    rnd_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_result;
  logic [3:0]    out_flags;

  always #5 clk = ~clk;

  recip_round_pack #(.sig_width(SW), .exp_width(EW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .q_sig(q_sig), .g_bit(g_bit), .r_bit(r_bit), .s_bit(s_bit),
    .in_sign(in_sign), .in_exp(in_exp), .d_frac_zero(d_frac_zero),
    .in_class(in_class), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  typedef struct {
    string       name;
    logic [SW:0] sig;
    logic [2:0]  grs;
    logic        sign;
    logic [7:0]  e;
    logic        dfz;
    logic [1:0]  cls;
    logic [1:0]  mode;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t        tab[$];
  logic [35:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  function automatic vec_t mk(string n, logic [SW:0] sig, logic [2:0] grs,
                              logic sign, logic [7:0] e, logic dfz,
                              logic [1:0] cls, logic [1:0] mode,
                              logic [31:0] res, logic [3:0] fl);
    vec_t v;
    v.name = n; v.sig = sig; v.grs = grs; v.sign = sign; v.e = e;
    v.dfz = dfz; v.cls = cls; v.mode = mode; v.res = res; v.fl = fl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    q_sig = v.sig;
    {g_bit, r_bit, s_bit} = v.grs;
    in_sign = v.sign;
    in_exp = v.e;
    d_frac_zero = v.dfz;
    in_class = v.cls;
    rnd_mode = v.mode;
    in_valid = 1'b1;
    sb.push_back({v.res, v.fl});
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b result=%h flags=%b, want 0 0 0",
               out_valid, out_result, out_flags);
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed;
    out_ready = 1'b1;
    foreach (tab[i]) begin
      logic [35:0] e;
      int n;
      @(posedge clk); #1 drive(tab[i]);
      @(negedge clk);
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1 in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s latency_early: out_valid=%b want 0", tab[i].name, out_valid);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s latency: out_valid=%b want 1", tab[i].name, out_valid);
      end
      checks++;
      if ({out_result, out_flags} !== e) begin
        errors++;
        $display("FAIL %s: result=%h flags=%b want result=%h flags=%b",
                 tab[i].name, out_result, out_flags, e[35:4], e[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int idx = 0, got = 0, cyc = 0, first = -1, last = -1;
    int n = 6;
    out_ready = 1'b1;
    @(posedge clk); #1 drive(tab[0]);
    while (got < n && cyc < 60) begin
      logic acc;
      logic [35:0] e;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: result=%h with empty scoreboard", out_result);
        end else begin
          e = sb.pop_front();
          if ({out_result, out_flags} !== e) begin
            errors++;
            $display("FAIL b2b_data: result=%h flags=%b want %h %b",
                     out_result, out_flags, e[35:4], e[3:0]);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < n) drive(tab[idx]);
        else in_valid = 1'b0;
      end
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want %0d", got, n);
    end
    checks++;
    if (last - first != n - 1) begin
      errors++;
      $display("FAIL b2b_throughput: span %0d cycles want %0d", last - first, n - 1);
    end
  endtask

  task automatic test_backpressure;
    logic [35:0] held;
    int idx = 2, got = 0, cyc = 0;
    out_ready = 1'b0;
    @(posedge clk); #1 drive(tab[0]);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept0: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1 drive(tab[1]);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept1: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1 drive(tab[2]);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    held = {out_result, out_flags};
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {out_result, out_flags} !== held) begin
        errors++;
        $display("FAIL bp_hold: in_ready=%b valid=%b result=%h want 0 1 %h",
                 in_ready, out_valid, out_result, held[35:4]);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    while (got < 4 && cyc < 60) begin
      logic acc;
      logic [35:0] e;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: result=%h with empty scoreboard", out_result);
        end else begin
          e = sb.pop_front();
          if ({out_result, out_flags} !== e) begin
            errors++;
            $display("FAIL bp_data%0d: result=%h flags=%b want %h %b",
                     got, out_result, out_flags, e[35:4], e[3:0]);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) drive(tab[idx]);
        else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (got != 4 || sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got=%0d left=%0d valid=%b want 4 0 0",
               got, sb.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid;
    logic [35:0] e;
    logic seen;
    out_ready = 1'b0;
    @(posedge clk); #1 drive(tab[1]);
    @(posedge clk); #1 drive(tab[2]);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_full: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_async: valid=%b result=%h flags=%b want 0 0 0",
               out_valid, out_result, out_flags);
    end
    sb.delete();
    @(negedge clk) reset = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: in_ready=%b want 1", in_ready);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_ghost: out_valid=1 want 0 after release");
    end
    @(posedge clk); #1 drive(tab[8]);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_result, out_flags} !== e) begin
      errors++;
      $display("FAIL rst_mid_after: valid=%b result=%h flags=%b want 1 %h %b",
               out_valid, out_result, out_flags, e[35:4], e[3:0]);
    end
  endtask

  initial begin
    tab.push_back(mk("pow2",        24'h800000, 3'b000, 0, 8'd128, 1, 0, 0, 32'h3F000000, 4'b0000));
    tab.push_back(mk("third_rne",   24'hAAAAAA, 3'b101, 0, 8'd128, 0, 0, 0, 32'h3EAAAAAB, 4'b0001));
    tab.push_back(mk("third_rtz",   24'hAAAAAA, 3'b101, 0, 8'd128, 0, 0, 1, 32'h3EAAAAAA, 4'b0001));
    tab.push_back(mk("third_rdn_n", 24'hAAAAAA, 3'b101, 1, 8'd128, 0, 0, 3, 32'hBEAAAAAB, 4'b0001));
    tab.push_back(mk("third_rup_p", 24'hAAAAAA, 3'b101, 0, 8'd128, 0, 0, 2, 32'h3EAAAAAB, 4'b0001));
    tab.push_back(mk("third_rup_n", 24'hAAAAAA, 3'b101, 1, 8'd128, 0, 0, 2, 32'hBEAAAAAA, 4'b0001));
    tab.push_back(mk("third_rdn_p", 24'hAAAAAA, 3'b101, 0, 8'd128, 0, 0, 3, 32'h3EAAAAAA, 4'b0001));
    tab.push_back(mk("tie_odd",     24'h800001, 3'b100, 0, 8'd128, 1, 0, 0, 32'h3F000002, 4'b0001));
    tab.push_back(mk("carry",       24'hFFFFFF, 3'b110, 0, 8'd127, 0, 0, 0, 32'h3F800000, 4'b0001));
    tab.push_back(mk("tie_even",    24'h800002, 3'b100, 0, 8'd128, 1, 0, 0, 32'h3F000002, 4'b0001));
    tab.push_back(mk("zero_neg",    24'h800000, 3'b000, 1, 8'd0,   0, 1, 0, 32'hFF800000, 4'b1000));
    tab.push_back(mk("inf_pos",     24'h800000, 3'b111, 0, 8'd255, 1, 2, 0, 32'h00000000, 4'b0000));
    tab.push_back(mk("inf_neg",     24'h800000, 3'b111, 1, 8'd255, 1, 2, 2, 32'h80000000, 4'b0000));
    tab.push_back(mk("nan",         24'hC00000, 3'b111, 1, 8'd255, 0, 3, 0, 32'h7FC00000, 4'b0000));
    tab.push_back(mk("unf",         24'h800000, 3'b000, 0, 8'd253, 0, 0, 0, 32'h00000000, 4'b0011));
    tab.push_back(mk("unf_neg",     24'h800000, 3'b000, 1, 8'd253, 0, 0, 1, 32'h80000000, 4'b0011));
    tab.push_back(mk("min_norm",    24'h800000, 3'b000, 0, 8'd252, 0, 0, 0, 32'h00800000, 4'b0000));
    tab.push_back(mk("ovf_rne",     24'hFFFFFF, 3'b110, 0, 8'd0,   1, 0, 0, 32'h7F800000, 4'b0101));
    tab.push_back(mk("ovf_rdn_n",   24'hFFFFFF, 3'b110, 1, 8'd0,   1, 0, 3, 32'hFF800000, 4'b0101));
    tab.push_back(mk("max_exp_rtz", 24'hFFFFFF, 3'b110, 0, 8'd0,   1, 0, 1, 32'h7F7FFFFF, 4'b0001));

    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
